// File: rtl/ret_stack.sv
// Return-address style LIFO stack with registered top/count/error outputs.
// Define RET_STACK_WRAP_EN to make a push into a full stack overwrite the oldest entry.
module ret_stack #(
  parameter int WIDTH      = 11,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      top,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ONE_CNT   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] TWO_IDX   = DEPTH_LOG2'(2);

  // Storage is circular: hp is the next free slot, the top entry lives at hp-1
  // and the oldest at hp-count, so a wrapping push naturally overwrites it.
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] hp;

  logic [DEPTH_LOG2-1:0] hp_nxt;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic [WIDTH-1:0]      top_nxt;
  logic                  ovf_nxt;
  logic                  unf_nxt;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] below_idx;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign below_idx = hp - TWO_IDX;

  always_comb begin
    hp_nxt    = hp;
    count_nxt = count;
    top_nxt   = top;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = hp;
    if (push && (!pop || empty)) begin
      if (!full) begin
        wr_en     = 1'b1;
        hp_nxt    = hp + 1'b1;
        count_nxt = count + 1'b1;
        top_nxt   = din;
      end else begin
        ovf_nxt = 1'b1;
`ifdef RET_STACK_WRAP_EN
        wr_en   = 1'b1;
        hp_nxt  = hp + 1'b1;
        top_nxt = din;
`endif
      end
    end else if (push && pop) begin
      // Replace the top in place; depth is unchanged.
      wr_en   = 1'b1;
      wr_idx  = hp - 1'b1;
      top_nxt = din;
    end else if (pop) begin
      if (empty) begin
        unf_nxt = 1'b1;
      end else begin
        hp_nxt    = hp - 1'b1;
        count_nxt = count - 1'b1;
        top_nxt   = (count == ONE_CNT) ? '0 : mem[below_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hp        <= '0;
      count     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      hp        <= hp_nxt;
      count     <= count_nxt;
      top       <= top_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  // Entries are never cleared; count gating keeps stale data invisible.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack (DEPTH_LOG2=2): directed vector table,
// a reset-with-push sequence, and random traffic against a queue model.
module tb_ret_stack;

  localparam int W  = 11;
  localparam int DL = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset, push, pop;
  logic [W-1:0]  din;
  logic [W-1:0]  top;
  logic [DL:0]   count;
  logic          empty, full, overflow, underflow;

  ret_stack #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // scoreboard: exp_q holds stack contents, oldest at index 0
  logic [W-1:0] exp_q[$];
  logic         exp_ovf, exp_unf;

  typedef struct {
    logic         rst, p, q;
    logic [W-1:0] d;
    logic [W-1:0] top;
    logic [DL:0]  cnt;
    logic         e, f, o, u;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic p, input logic q, input logic [W-1:0] d);
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (r) begin
      exp_q.delete();
    end else if (p && q) begin
      if (exp_q.size() == 0) exp_q.push_back(d);
      else exp_q[exp_q.size()-1] = d;
    end else if (p) begin
      if (exp_q.size() == D) begin
        exp_ovf = 1'b1;
`ifdef RET_STACK_WRAP_EN
        void'(exp_q.pop_front());
        exp_q.push_back(d);
`endif
      end else begin
        exp_q.push_back(d);
      end
    end else if (q) begin
      if (exp_q.size() == 0) exp_unf = 1'b1;
      else void'(exp_q.pop_back());
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] et;
    et = (exp_q.size() == 0) ? '0 : exp_q[exp_q.size()-1];
    chk({tag, ".top"},       32'(top),       32'(et));
    chk({tag, ".count"},     32'(count),     32'(exp_q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(exp_q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(exp_q.size() == D));
    chk({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  // driver: called #1 after a rising edge; samples results #1 after the next
  task automatic apply(input logic r, input logic p, input logic q, input logic [W-1:0] d,
                       input string tag);
    reset = r; push = p; pop = q; din = d;
    model_step(r, p, q, d);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic add(input logic rst, input logic p, input logic q, input int d,
                     input int t, input int c, input logic e, input logic f,
                     input logic o, input logic u);
    vec_t v;
    v.rst = rst; v.p = p; v.q = q; v.d = W'(d);
    v.top = W'(t); v.cnt = (DL+1)'(c);
    v.e = e; v.f = f; v.o = o; v.u = u;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    @(posedge clk); #1;

    //   rst p q  din    top    cnt e f o u
    add(1, 0, 0, 'h000, 'h000, 0, 1, 0, 0, 0);
    add(0, 1, 0, 'h001, 'h001, 1, 0, 0, 0, 0);
    add(0, 1, 0, 'h002, 'h002, 2, 0, 0, 0, 0);
    add(0, 1, 0, 'h003, 'h003, 3, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h002, 2, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h001, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 1);
    add(0, 0, 0, 'h000, 'h000, 0, 1, 0, 0, 0);
    add(0, 1, 0, 'h0AA, 'h0AA, 1, 0, 0, 0, 0);
    add(0, 1, 0, 'h0BB, 'h0BB, 2, 0, 0, 0, 0);
    add(0, 1, 1, 'h0CC, 'h0CC, 2, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h0AA, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 0);
    add(0, 1, 1, 'h007, 'h007, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 0);
    add(0, 1, 0, 'h001, 'h001, 1, 0, 0, 0, 0);
    add(0, 1, 0, 'h002, 'h002, 2, 0, 0, 0, 0);
    add(0, 1, 0, 'h003, 'h003, 3, 0, 0, 0, 0);
    add(0, 1, 0, 'h004, 'h004, 4, 0, 1, 0, 0);
`ifdef RET_STACK_WRAP_EN
    add(0, 1, 0, 'h005, 'h005, 4, 0, 1, 1, 0);
    add(0, 0, 1, 'h000, 'h004, 3, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h003, 2, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h002, 1, 0, 0, 0, 0);
`else
    add(0, 1, 0, 'h005, 'h004, 4, 0, 1, 1, 0);
    add(0, 0, 1, 'h000, 'h003, 3, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h002, 2, 0, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h001, 1, 0, 0, 0, 0);
`endif
    add(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 1);
    add(0, 0, 1, 'h000, 'h000, 0, 1, 0, 0, 1);
    add(0, 0, 0, 'h000, 'h000, 0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      apply(tbl[i].rst, tbl[i].p, tbl[i].q, tbl[i].d, {tag, ".model"});
      chk({tag, ".top"},       32'(top),       32'(tbl[i].top));
      chk({tag, ".count"},     32'(count),     32'(tbl[i].cnt));
      chk({tag, ".empty"},     32'(empty),     32'(tbl[i].e));
      chk({tag, ".full"},      32'(full),      32'(tbl[i].f));
      chk({tag, ".overflow"},  32'(overflow),  32'(tbl[i].o));
      chk({tag, ".underflow"}, 32'(underflow), 32'(tbl[i].u));
    end

    // reset asserted together with push after filling past capacity
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b0, W'(16 + i), "fill");
    apply(1'b1, 1'b1, 1'b0, W'(12'h055), "rst_push");
    chk("rst_push.count", 32'(count), 32'd0);
    chk("rst_push.top",   32'(top),   32'd0);
    chk("rst_push.empty", 32'(empty), 32'd1);
    apply(1'b0, 1'b0, 1'b1, '0, "rst_pop");
    chk("rst_pop.underflow", 32'(underflow), 32'd1);

    // random traffic against the queue model
    for (int i = 0; i < 800; i++) begin
      logic r, p, q;
      r = ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 9) < 6);
      q = ($urandom_range(0, 9) < 5);
      apply(r, p, q, W'($urandom_range(0, (1 << W) - 1)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
